vga_scanout: RTL and testbench

- Parametrised successor to the fixed 640x480 VGA controller.
- Generates programmable VGA timing and streams pixels from an external synchronous-read frame-buffer RAM instead of an in-module array.
- Supports configurable colour depth, power-of-two pixel replication (low-res playfield upscaled to the panel) and double buffering with a tear-free swap at vertical blank.
- Sits between the game renderer (which writes the back buffer) and the board VGA pins.

---
 rtl/vga_scanout.sv | 151 +++++++++++++++
 tb/tb_vga_scanout.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// Programmable VGA timing generator that streams pixels from an external
// synchronous-read frame buffer, with pixel replication and double buffering.
module vga_scanout #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter int   COLOR_W     = 1,
  parameter int   SCALE_SHIFT = 0,
  parameter int   MEM_LAT     = 1,
  parameter logic SYNC_POL    = 1'b0,
  localparam int  H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  FB_W        = H_ACTIVE >> SCALE_SHIFT,
  localparam int  FB_H        = V_ACTIVE >> SCALE_SHIFT,
  localparam int  FB_SIZE     = FB_W * FB_H,
  localparam int  CW          = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL),
  localparam int  AW          = $clog2(2 * FB_SIZE)
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   fb_rd_en,
  output logic [AW-1:0]          fb_addr,
  input  logic [3*COLOR_W-1:0]   fb_data,
  input  logic                   swap_req,
  output logic                   swap_ack,
  output logic                   front_buf,
  output logic [COLOR_W-1:0]     vga_r,
  output logic [COLOR_W-1:0]     vga_g,
  output logic [COLOR_W-1:0]     vga_b,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   in_display,
  output logic [CW-1:0]          count_x,
  output logic [CW-1:0]          count_y,
  output logic                   frame_start
);

  localparam int STAGES = MEM_LAT + 1;

  localparam logic [CW-1:0] X_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_ACT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] Y_ACT   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] Y_SWAP  = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] Y_MASK  = CW'((1 << SCALE_SHIFT) - 1);

  localparam logic [AW-1:0] FB_W_A    = AW'(FB_W);
  localparam logic [AW-1:0] FB_SIZE_A = AW'(FB_SIZE);

  logic              last_x, last_y, active, h_sync, v_sync;
  logic              swap_fire, pending;
  logic [CW-1:0]     y_next;
  logic [AW-1:0]     line_base;
  logic [STAGES:1]   act_pipe, hs_pipe, vs_pipe;

  assign last_x    = (count_x == X_LAST);
  assign last_y    = (count_y == Y_LAST);
  assign y_next    = last_y ? '0 : count_y + 1'b1;
  assign active    = (count_x < X_ACT) && (count_y < Y_ACT);
  assign h_sync    = (count_x >= HS_BEG) && (count_x <= HS_LAST);
  assign v_sync    = (count_y >= VS_BEG) && (count_y <= VS_LAST);
  assign swap_fire = last_x && (count_y == Y_SWAP) && (pending || swap_req);

  // Combinational so it is visible in the very first unreset cycle at (0,0).
  assign frame_start = (count_x == '0) && (count_y == '0) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_x <= '0;
      count_y <= '0;
    end else begin
      count_x <= last_x ? '0 : count_x + 1'b1;
      if (last_x) count_y <= y_next;
    end
  end

  // Line base tracks front_buf*FB_SIZE + (y>>S)*FB_W; stepped once per 2^S lines.
  always_ff @(posedge clock) begin
    if (reset) begin
      line_base <= '0;
    end else if (last_x) begin
      if (last_y)
        line_base <= (front_buf ^ swap_fire) ? FB_SIZE_A : '0;
      else if ((y_next & Y_MASK) == '0)
        line_base <= line_base + FB_W_A;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fb_rd_en <= 1'b0;
      fb_addr  <= '0;
    end else begin
      fb_rd_en <= active;
      fb_addr  <= line_base + AW'(count_x >> SCALE_SHIFT);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending   <= 1'b0;
      front_buf <= 1'b0;
      swap_ack  <= 1'b0;
    end else begin
      swap_ack <= swap_fire;
      if (swap_fire) begin
        front_buf <= ~front_buf;
        pending   <= 1'b0;
      end else if (swap_req) begin
        pending   <= 1'b1;
      end
    end
  end

  // Timing flags ride alongside the read so they meet the returned data.
  always_ff @(posedge clock) begin
    if (reset) begin
      act_pipe <= '0;
      hs_pipe  <= '0;
      vs_pipe  <= '0;
    end else begin
      act_pipe <= {act_pipe[STAGES-1:1], active};
      hs_pipe  <= {hs_pipe[STAGES-1:1], h_sync};
      vs_pipe  <= {vs_pipe[STAGES-1:1], v_sync};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in_display          <= 1'b0;
      {vga_b, vga_g, vga_r} <= '0;
      hsync_out           <= ~SYNC_POL;
      vsync_out           <= ~SYNC_POL;
    end else begin
      in_display          <= act_pipe[STAGES];
      {vga_b, vga_g, vga_r} <= act_pipe[STAGES] ? fb_data : '0;
      hsync_out           <= hs_pipe[STAGES] ? SYNC_POL : ~SYNC_POL;
      vsync_out           <= vs_pipe[STAGES] ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Randomized scoreboard bench for vga_scanout on a shrunken raster with a
// latency-2 frame-buffer model; expectations come from a beam-position model.
module tb_vga_scanout;
  localparam int HA = 32, HFP = 4, HSY = 6, HBP = 6;
  localparam int VA = 16, VFP = 2, VSY = 2, VBP = 4;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int F  = HT * VT;
  localparam int CWD = 2, S = 1, ML = 2, L = ML + 2;
  localparam int FBW = HA >> S, FBH = VA >> S, FBS = FBW * FBH;
  localparam int CW = $clog2((HT > VT) ? HT : VT);
  localparam int AW = $clog2(2 * FBS);
  localparam int PW = 3 + 3 * CWD;

  logic clock = 1'b0, reset = 1'b1, swap_req = 1'b0;
  logic fb_rd_en, swap_ack, front_buf, hsync_out, vsync_out, in_display, frame_start;
  logic [AW-1:0] fb_addr;
  logic [3*CWD-1:0] fb_data;
  logic [CWD-1:0] vga_r, vga_g, vga_b;
  logic [CW-1:0] count_x, count_y;

  vga_scanout #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
                .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
                .COLOR_W(CWD), .SCALE_SHIFT(S), .MEM_LAT(ML), .SYNC_POL(1'b0)) dut (
    .clock(clock), .reset(reset), .fb_rd_en(fb_rd_en), .fb_addr(fb_addr),
    .fb_data(fb_data), .swap_req(swap_req), .swap_ack(swap_ack),
    .front_buf(front_buf), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .in_display(in_display),
    .count_x(count_x), .count_y(count_y), .frame_start(frame_start));

  always #5 clock = ~clock;

  // Frame-buffer contents are a fixed scramble of the address.
  function automatic logic [3*CWD-1:0] ram_word(int a);
    int v;
    v = (a * 13) ^ (a >> 3) ^ 5;
    return v[3*CWD-1:0];
  endfunction

  logic [AW-1:0]    ram_a [ML];
  logic             ram_v [ML];
  logic [3*CWD-1:0] ram_g;
  always @(posedge clock) begin
    ram_a[0] <= fb_addr;
    ram_v[0] <= fb_rd_en;
    for (int i = 1; i < ML; i++) begin
      ram_a[i] <= ram_a[i-1];
      ram_v[i] <= ram_v[i-1];
    end
    ram_g <= (3*CWD)'($urandom);
  end
  assign fb_data = ram_v[ML-1] ? ram_word(int'(ram_a[ML-1])) : ram_g;

  typedef struct { int x; int y; bit fb; bit pend; bit ack; } beam_t;
  typedef struct { int cx; int cy; bit fs0; bit fbuf; bit ack; bit rd; bit chk_addr; int addr; logic [PW-1:0] pins; } exp_t;

  beam_t cur;
  beam_t hist[$];
  exp_t  exp_q[$];
  int    since_rst = 0;
  int    checks = 0, errors = 0;

  localparam logic [PW-1:0] PINS_RST = {1'b0, 1'b1, 1'b1, {(3*CWD){1'b0}}};

  function automatic bit is_act(int x, int y);
    return (x < HA) && (y < VA);
  endfunction

  function automatic int addr_of(beam_t b);
    return int'(b.fb) * FBS + (b.y >> S) * FBW + (b.x >> S);
  endfunction

  function automatic logic [PW-1:0] pins_of(beam_t b);
    bit a, hs, vs;
    logic [3*CWD-1:0] d;
    a  = is_act(b.x, b.y);
    hs = (b.x >= HA + HFP) && (b.x < HA + HFP + HSY);
    vs = (b.y >= VA + VFP) && (b.y < VA + VFP + VSY);
    d  = a ? ram_word(addr_of(b)) : '0;
    return {a, !hs, !vs, d};
  endfunction

  // Reference model: beam position, buffer ownership, and expected pins per cycle.
  always @(posedge clock) begin : model
    beam_t prv, nb;
    exp_t e;
    bit fire;
    prv = cur;
    if (reset) begin
      nb = '{0, 0, 1'b0, 1'b0, 1'b0};
      since_rst = 0;
    end else begin
      fire    = (prv.x == HT-1) && (prv.y == VA-1) && (prv.pend || swap_req);
      nb.fb   = prv.fb ^ fire;
      nb.pend = fire ? 1'b0 : (prv.pend | swap_req);
      nb.ack  = fire;
      nb.x    = (prv.x + 1) % HT;
      nb.y    = (prv.x == HT-1) ? (prv.y + 1) % VT : prv.y;
      since_rst++;
    end
    cur = nb;
    hist.push_back(nb);
    if (hist.size() > L + 1) void'(hist.pop_front());
    e.cx = nb.x; e.cy = nb.y; e.fs0 = (nb.x == 0) && (nb.y == 0);
    e.fbuf = nb.fb; e.ack = nb.ack;
    e.rd = !reset && is_act(prv.x, prv.y);
    e.addr = reset ? 0 : addr_of(prv);
    e.chk_addr = reset || e.rd;
    e.pins = (since_rst >= L) ? pins_of(hist[hist.size()-1-L]) : PINS_RST;
    exp_q.push_back(e);
  end

  always @(negedge clock) begin : monitor
    exp_t e;
    logic [PW-1:0] got_p;
    logic [2*CW+2:0] got_b, exp_b;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got_p = {in_display, hsync_out, vsync_out, vga_b, vga_g, vga_r};
      checks++;
      if (got_p !== e.pins) begin
        errors++;
        $display("FAIL pins at beam(%0d,%0d): got %h expected %h", e.cx, e.cy, got_p, e.pins);
      end
      got_b = {count_x, count_y, frame_start, front_buf, swap_ack};
      exp_b = {CW'(e.cx), CW'(e.cy), e.fs0 && !reset, e.fbuf, e.ack};
      checks++;
      if (got_b !== exp_b) begin
        errors++;
        $display("FAIL beam {x,y,fs,fb,ack}: got %h expected %h", got_b, exp_b);
      end
      checks++;
      if (fb_rd_en !== e.rd) begin
        errors++;
        $display("FAIL rd_en at beam(%0d,%0d): got %b expected %b", e.cx, e.cy, fb_rd_en, e.rd);
      end
      if (e.chk_addr) begin
        checks++;
        if (fb_addr !== AW'(e.addr)) begin
          errors++;
          $display("FAIL fb_addr at beam(%0d,%0d): got %0d expected %0d", e.cx, e.cy, fb_addr, e.addr);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_beam(input int x, input int y);
    int k;
    k = 0;
    while (!(cur.x == x && cur.y == y) && k < 2 * F) begin
      tick();
      k++;
    end
    if (k >= 2 * F) begin
      checks++;
      errors++;
      $display("FAIL wait_beam timeout: got beam(%0d,%0d) required (%0d,%0d)", cur.x, cur.y, x, y);
    end
  endtask

  task automatic random_swaps(input int n, input int odds);
    repeat (n) begin
      swap_req = ($urandom_range(odds - 1) == 0);
      tick();
    end
    swap_req = 1'b0;
  endtask

  initial begin
    int acks;
    logic fb0;
    reset = 1'b1;
    swap_req = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(F + F / 4);
    random_swaps(2 * F, 150);

    // Flush any pending request, then request exactly on the swap clock.
    wait_beam(HT-1, VA-1);
    tick();
    wait_beam(HT-1, VA-1);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    checks++;
    if (swap_ack !== 1'b1) begin
      errors++;
      $display("FAIL boundary_ack: got %b required 1", swap_ack);
    end

    // Request held high across three frames.
    wait_beam(0, VA);
    fb0 = front_buf;
    swap_req = 1'b1;
    acks = 0;
    tick();
    repeat (3 * F) begin
      if (swap_ack === 1'b1) acks++;
      tick();
    end
    swap_req = 1'b0;
    checks++;
    if (acks != 3) begin
      errors++;
      $display("FAIL held_ack_count: got %0d required 3", acks);
    end
    checks++;
    if (front_buf !== ~fb0) begin
      errors++;
      $display("FAIL held_front_buf: got %b required %b", front_buf, ~fb0);
    end

    // Mid-frame resets, with a swap request in flight that must be dropped.
    repeat (3) begin
      wait_beam($urandom_range(HA - 1), $urandom_range(VA - 1));
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      tick($urandom_range(4));
      reset = 1'b1;
      tick($urandom_range(2, 1));
      reset = 1'b0;
      tick($urandom_range(F, F / 2));
    end

    random_swaps(F + F / 2, 100);
    tick(L + 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
